raster_scan_controller: RTL
===========================

Name: raster_scan_controller

Overview:
- Generates the raster-order pixel coordinate stream (x, y) for one frame that feeds the filter datapath and its address counters.
- Started by a one-cycle start pulse; steps one pixel per accepted transfer on a valid/ready handshake.
- Flags start-of-frame, end-of-line and end-of-frame, and pulses done after the last pixel is accepted.
- Sits upstream of the saturating position counters and line buffers, driving their enable and reset.

Parameters:
- X_WIDTH, 10, width of x coordinate and width limit.
- Y_WIDTH, 10, width of y coordinate and height limit.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle frame start request; honoured only in IDLE.
- abort  input  1  synchronous frame abandon.
- x_last  input  X_WIDTH  last column index (frame width minus 1).
- y_last  input  Y_WIDTH  last row index (frame height minus 1).
- out_ready  input  1  downstream accepts the current coordinate.
- out_valid  output  1  x/y/flags are valid.
- x  output  X_WIDTH  current column.
- y  output  Y_WIDTH  current row.
- sof  output  1  high with the pixel at (0,0).
- eol  output  1  high when x == latched x_last.
- eof  output  1  high at (x_last, y_last).
- busy  output  1  high in SCAN.
- done  output  1  one-cycle pulse after the final transfer.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE; x=0; y=0; out_valid=0; sof=0; eol=0; eof=0; busy=0; done=0; latched limits=0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 latches x_last/y_last into internal registers and sets x=y=0.
  - Next cycle: SCAN, with out_valid=1 and busy=1.
- SCAN:
  - A transfer is out_valid && out_ready. x/y and all flags hold while out_ready=0.
  - On a transfer with x != xl: x <= x+1.
  - On a transfer with x == xl and y != yl: x <= 0, y <= y+1.
  - On a transfer at (xl, yl): out_valid <= 0, busy <= 0, move to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. x/y hold their final values.
- Flags (combinational from registered x/y and latched limits, gated by out_valid):
  - sof = (x==0 && y==0).
  - eol = (x==xl).
  - eof = eol && (y==yl).
- Throughput and latency:
  - One pixel per cycle when out_ready is held high.
  - A frame takes (xl+1)*(yl+1) transfers.
  - First valid appears 1 cycle after start.
- Boundaries:
  - x_last=0 and y_last=0: single-pixel frame; sof, eol and eof all high on the same beat.
  - x_last/y_last change during SCAN: ignored, because limits are latched at start.
  - start outside IDLE: ignored; start in DONE is also dropped.
  - abort in any state: next cycle IDLE with out_valid=0 and busy=0, done not asserted, x/y cleared to 0.
  - reset: same as abort; reset has priority over everything.
  - abort together with start in IDLE: abort wins and start is dropped.
  - No arithmetic overflow is possible, because coordinates never exceed the latched limits.

Optional Feature:
- Macro BORDER_FLAG_EN.
- Defined:
  - Adds output border (1 bit), high when out_valid && (x==0 || y==0 || x==xl || y==yl).
  - Used by the 3x3 filter for edge replication. Registered with the same timing as x/y.
- Undefined:
  - Port absent, no extra logic.
  - All other behaviour identical.

Decomposition:
- Package raster_scan_pkg:
  - State enum (IDLE, SCAN, DONE) and default X_WIDTH/Y_WIDTH constants.
  - Transfer/flag helper functions.
- Sub-module wrap_counter (WIDTH, last, step, clear; outputs value and wrap):
  - Instantiated once for x; its wrap output gates the step of the y instance.

Test Plan:
- Reset mid-scan: start with x_last=3, y_last=1; reset at the 3rd transfer → next cycle out_valid=0, x=y=0, state IDLE, no done.
- Full frame: x_last=3, y_last=2, out_ready=1 → 12 transfers; eol on x=3 for each y; eof only at (3,2); done pulses 1 cycle after the last beat.
- Backpressure: out_ready toggles 1,0,0,1 → x/y/flags stable during the stall; no pixel skipped or repeated.
- Single pixel: x_last=0, y_last=0 → one beat with sof=eol=eof=1, then done.
- Limit change and late start: change x_last from 3 to 7 mid-frame, and pulse start during SCAN → frame still ends at x=3; the extra start is ignored.
- Abort: abort at (2,1) → IDLE next cycle, done=0; a new start then begins at (0,0). With BORDER_FLAG_EN defined, border=1 exactly on perimeter pixels.

Source files
------------

// File: rtl/raster_scan_pkg.sv
// Shared types and helpers for the raster scan controller and its counters.
package raster_scan_pkg;

  localparam int X_WIDTH_DEF = 10;
  localparam int Y_WIDTH_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_transfer(input logic valid, input logic ready);
    return valid && ready;
  endfunction

  function automatic logic gate_flag(input logic valid, input logic cond);
    return valid && cond;
  endfunction

endpackage

// File: rtl/raster_scan_controller_wrap_counter.sv
// Up-counter that wraps to zero after reaching a runtime limit.
// wrap is high whenever value sits at the limit, independent of step.
module wrap_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  assign wrap = (value == last);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      value <= '0;
    end else if (step) begin
      value <= wrap ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/raster_scan_controller.sv
// Raster-order (x, y) coordinate generator for one frame, one pixel per valid/ready transfer.
// Optional BORDER_FLAG_EN adds a perimeter flag output for edge replication.
module raster_scan_controller
  import raster_scan_pkg::*;
#(
  parameter int X_WIDTH = X_WIDTH_DEF,
  parameter int Y_WIDTH = Y_WIDTH_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [X_WIDTH-1:0] x_last,
  input  logic [Y_WIDTH-1:0] y_last,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               sof,
  output logic               eol,
  output logic               eof,
  output logic               busy,
  output logic               done
`ifdef BORDER_FLAG_EN
  ,
  output logic               border
`endif
);

  state_t state, state_next;

  logic [X_WIDTH-1:0] xl;
  logic [Y_WIDTH-1:0] yl;

  logic accept_start;
  logic clear;
  logic transfer;
  logic x_wrap, y_wrap;
  logic at_end;
  logic x_step, y_step;

  assign out_valid = (state == SCAN);
  assign busy      = (state == SCAN);
  assign done      = (state == DONE);

  // abort beats start when both arrive in IDLE
  assign accept_start = (state == IDLE) && start && !abort;
  assign clear        = abort || accept_start;

  assign transfer = is_transfer(out_valid, out_ready);
  assign at_end   = x_wrap && y_wrap;

  // the final pixel does not step, so x/y keep their last values in DONE
  assign x_step = transfer && !at_end;
  assign y_step = transfer && x_wrap && !at_end;

  always_ff @(posedge clock) begin
    if (reset) begin
      xl <= '0;
      yl <= '0;
    end else if (accept_start) begin
      xl <= x_last;
      yl <= y_last;
    end
  end

  wrap_counter #(.WIDTH(X_WIDTH)) u_x_counter (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .step  (x_step),
    .last  (xl),
    .value (x),
    .wrap  (x_wrap)
  );

  wrap_counter #(.WIDTH(Y_WIDTH)) u_y_counter (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .step  (y_step),
    .last  (yl),
    .value (y),
    .wrap  (y_wrap)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (transfer && at_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  assign sof = gate_flag(out_valid, (x == '0) && (y == '0));
  assign eol = gate_flag(out_valid, x_wrap);
  assign eof = gate_flag(out_valid, at_end);

`ifdef BORDER_FLAG_EN
  assign border = gate_flag(out_valid, (x == '0) || (y == '0) || x_wrap || y_wrap);
`endif

endmodule
